dkong3_obj_linebuf: RTL and testbench

- Double-buffered sprite line buffer. It sits directly upstream of the colour palette stage and produces the 6-bit object pixel (2 pixel bits plus 4 palette bits) that the palette compares against background.
- During line N, the sprite drawer writes pixels into the back bank. The video side reads the front bank in step with the 6 MHz pixel enable and clears each location as it reads it.
- Banks swap on a line strobe.

---
 rtl/dkong3_pkg.sv | 23 ++
 rtl/dkong3_linebuf_ram.sv | 26 ++
 rtl/dkong3_obj_linebuf.sv | 159 +++++++++++++++
 tb/tb_dkong3_obj_linebuf.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/dkong3_pkg.sv
// Shared definitions for the Donkey Kong 3 object line buffer:
// default geometry, pixel field positions and write-FSM states.
package dkong3_pkg;

   localparam int AW_DEF  = 8;
   localparam int DW_DEF  = 6;
   localparam int PIX_LSB = 0;
   localparam int PIX_MSB = 1;
   localparam int PAL_LSB = 2;

   typedef enum logic [1:0] {
      WR_INIT,
      WR_IDLE,
      WR_CHECK,
      WR_COMMIT
   } wr_state_e;

   // A pixel code of zero is transparent.
   function automatic logic isOpaque(input logic [PIX_MSB:PIX_LSB] pix);
      return pix != '0;
   endfunction

endpackage

// File: rtl/dkong3_linebuf_ram.sv
// One line-buffer bank: 2^AW x DW simple dual-port RAM.
// Synchronous write; registered read that holds its value while re_i is low.
module dkong3_linebuf_ram #(
   parameter int AW = 8,
   parameter int DW = 6
) (
   input  logic          clk_i,
   input  logic          we_i,
   input  logic [AW-1:0] waddr_i,
   input  logic [DW-1:0] wdata_i,
   input  logic          re_i,
   input  logic [AW-1:0] raddr_i,
   output logic [DW-1:0] rdata_o
);

   logic [DW-1:0] mem_q [0:(1<<AW)-1];
   logic [DW-1:0] rdata_q;

   always_ff @(posedge clk_i) begin
      if (we_i) mem_q[waddr_i] <= wdata_i;
      if (re_i) rdata_q <= mem_q[raddr_i];
   end

   assign rdata_o = rdata_q;

endmodule

// File: rtl/dkong3_obj_linebuf.sv
// Double-buffered sprite line buffer: the drawer fills the back bank while
// the video side reads-and-clears the front bank; banks swap on the line strobe.
module dkong3_obj_linebuf
   import dkong3_pkg::*;
#(
   parameter int AW = AW_DEF,
   parameter int DW = DW_DEF
) (
   input  logic          I_CLK_24M,
   input  logic          I_RESETn,
   input  logic          I_CLK_6M,
   input  logic          I_LINE_SWAP,
   input  logic          I_WR_EN,
   input  logic [AW-1:0] I_WR_X,
   input  logic [DW-1:0] I_WR_D,
   output logic          O_WR_RDY,
   input  logic          I_RD_EN,
   input  logic [AW-1:0] I_RD_X,
   output logic [DW-1:0] O_OBJ_D,
   output logic          O_INIT_DONE
);

   wr_state_e     state_q, state_d;
   logic [AW-1:0] cnt_q, cnt_d;
   logic          initDone_q;
   logic          front_q;
   logic          clk6m_q;
   logic          ce6m;
   logic          accept;
   logic          commitWe;
   logic          vidRd;

   logic [AW-1:0] wrX_q;
   logic [DW-1:0] wrD_q;
   logic          wrBank_q;

   logic          rdPend_q;
   logic          rdBank_q;
   logic [AW-1:0] rdX_q;
   logic [DW-1:0] obj_q;

   logic [1:0]    we;
   logic [1:0]    re;
   logic [AW-1:0] waddr [2];
   logic [AW-1:0] raddr [2];
   logic [DW-1:0] wdata [2];
   logic [DW-1:0] rdata [2];

   assign ce6m  = I_CLK_6M & ~clk6m_q;
   assign vidRd = ce6m & I_RD_EN & (state_q != WR_INIT);

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      accept   = 1'b0;
      commitWe = 1'b0;
      case (state_q)
         WR_INIT: begin
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == {AW{1'b1}}) state_d = WR_IDLE;
         end
         WR_IDLE: begin
            accept = I_WR_EN;
            if (I_WR_EN) state_d = WR_CHECK;
         end
         WR_CHECK: state_d = WR_COMMIT;
         WR_COMMIT: begin
            // First opaque pixel wins; transparent pixels never overwrite.
            commitWe = ~isOpaque(rdata[wrBank_q][PIX_MSB:PIX_LSB]) &
                       isOpaque(wrD_q[PIX_MSB:PIX_LSB]);
            state_d  = WR_IDLE;
         end
         default: state_d = WR_INIT;
      endcase
   end

   // Per-bank port steering. Init sweep owns both write ports; otherwise the
   // front bank's write port carries the clear and the back bank's the commit.
   // The video read takes precedence on a read port in the unusual case where
   // a swap lands between accept and check while the display is active.
   always_comb begin
      for (int b = 0; b < 2; b++) begin
         we[b]    = 1'b0;
         waddr[b] = rdX_q;
         wdata[b] = '0;
         re[b]    = 1'b0;
         raddr[b] = wrX_q;
         if (state_q == WR_INIT) begin
            we[b]    = 1'b1;
            waddr[b] = cnt_q;
         end else if (rdPend_q && (rdBank_q == 1'(b))) begin
            we[b]    = 1'b1;
            waddr[b] = rdX_q;
         end else if (commitWe && (wrBank_q == 1'(b))) begin
            we[b]    = 1'b1;
            waddr[b] = wrX_q;
            wdata[b] = wrD_q;
         end
         if (vidRd && (front_q == 1'(b))) begin
            re[b]    = 1'b1;
            raddr[b] = I_RD_X;
         end else if ((state_q == WR_CHECK) && (wrBank_q == 1'(b))) begin
            re[b]    = 1'b1;
         end
      end
   end

   always_ff @(posedge I_CLK_24M) begin
      if (!I_RESETn) begin
         state_q    <= WR_INIT;
         cnt_q      <= '0;
         initDone_q <= 1'b0;
         front_q    <= 1'b0;
         clk6m_q    <= 1'b0;
         rdPend_q   <= 1'b0;
         obj_q      <= '0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         clk6m_q  <= I_CLK_6M;
         rdPend_q <= vidRd;
         if ((state_q == WR_INIT) && (state_d == WR_IDLE)) initDone_q <= 1'b1;
         if (I_LINE_SWAP && (state_q != WR_INIT)) front_q <= ~front_q;
         if (rdPend_q) obj_q <= rdata[rdBank_q];
         else if (ce6m) obj_q <= '0;
      end
   end

   always_ff @(posedge I_CLK_24M) begin
      if (accept) begin
         wrX_q    <= I_WR_X;
         wrD_q    <= I_WR_D;
         wrBank_q <= ~front_q;
      end
      if (vidRd) begin
         rdX_q    <= I_RD_X;
         rdBank_q <= front_q;
      end
   end

   for (genvar g = 0; g < 2; g++) begin : g_bank
      dkong3_linebuf_ram #(.AW(AW), .DW(DW)) u_ram (
         .clk_i   (I_CLK_24M),
         .we_i    (we[g]),
         .waddr_i (waddr[g]),
         .wdata_i (wdata[g]),
         .re_i    (re[g]),
         .raddr_i (raddr[g]),
         .rdata_o (rdata[g])
      );
   end

   // Fresh data is shown straight from the RAM in the cycle after ce_6m,
   // then held in obj_q so later bank reads cannot disturb the output.
   assign O_OBJ_D     = rdPend_q ? rdata[rdBank_q] : obj_q;
   assign O_WR_RDY    = (state_q == WR_IDLE);
   assign O_INIT_DONE = initDone_q;

endmodule

// File: tb/tb_dkong3_obj_linebuf.sv
// Self-checking bench for the object line buffer: directed vector table,
// hand-written corner sequences and random traffic against a bank model.
module tb_dkong3_obj_linebuf;

   typedef enum int {OP_WR, OP_SWAP, OP_RD} op_e;

   typedef struct {
      op_e        op;
      logic [7:0] x;
      logic [5:0] d;
      logic       en;
      logic [5:0] exp;
   } vec_t;

   logic       clk = 1'b0;
   logic       resetN;
   logic       clk6m;
   logic       swp;
   logic       wrEn;
   logic [7:0] wrX;
   logic [5:0] wrD;
   logic       wrRdy;
   logic       rdEn;
   logic [7:0] rdX;
   logic [5:0] objD;
   logic       initDone;

   int total = 0;
   int bad   = 0;

   logic [5:0] mdl [2][256];
   bit         mFront;

   vec_t tbl [13];

   always #5 clk = ~clk;

   dkong3_obj_linebuf #(.AW(8), .DW(6)) dut (
      .I_CLK_24M   (clk),
      .I_RESETn    (resetN),
      .I_CLK_6M    (clk6m),
      .I_LINE_SWAP (swp),
      .I_WR_EN     (wrEn),
      .I_WR_X      (wrX),
      .I_WR_D      (wrD),
      .O_WR_RDY    (wrRdy),
      .I_RD_EN     (rdEn),
      .I_RD_X      (rdX),
      .O_OBJ_D     (objD),
      .O_INIT_DONE (initDone)
   );

   initial begin
      #1_000_000;
      $display("[TB] FAIL watchdog: simulation still running, required finish");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string name, input int act, input int exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic modelReset();
      for (int b = 0; b < 2; b++)
         for (int a = 0; a < 256; a++) mdl[b][a] = '0;
      mFront = 1'b0;
   endtask

   // Called at a negedge with reset asserted; releases it and times the sweep.
   task automatic waitInit();
      int  n = 0;
      bit  objZero = 1'b1;
      resetN = 1'b1;
      modelReset();
      for (int i = 1; i <= 400; i++) begin
         @(posedge clk); #1;
         if (objD != 0) objZero = 1'b0;
         if (initDone) begin
            n = i;
            break;
         end
      end
      checkOutput("initCycles", n, 256);
      checkOutput("initRdy", int'(wrRdy), 1);
      checkOutput("initObjZero", int'(objZero), 1);
      @(negedge clk);
   endtask

   task automatic waitRdy();
      for (int i = 0; i < 20 && !wrRdy; i++) @(negedge clk);
      checkOutput("wrRdy", int'(wrRdy), 1);
   endtask

   // Starts and ends at a negedge with the write FSM back in idle.
   task automatic doWrite(input logic [7:0] x, input logic [5:0] d, input bit swapAtCheck);
      bit tgt;
      waitRdy();
      wrEn = 1'b1; wrX = x; wrD = d;
      tgt = ~mFront;
      if (mdl[tgt][x][1:0] == 2'b00 && d[1:0] != 2'b00) mdl[tgt][x] = d;
      @(negedge clk);
      wrEn = 1'b0;
      if (swapAtCheck) begin
         swp = 1'b1;
         mFront = ~mFront;
      end
      @(negedge clk);
      swp = 1'b0;
      @(negedge clk);
   endtask

   task automatic doSwap();
      swp = 1'b1;
      mFront = ~mFront;
      @(negedge clk);
      swp = 1'b0;
      @(negedge clk);
   endtask

   // One ce_6m read: got is sampled the cycle after ce, held three cycles later.
   task automatic doRead(input logic [7:0] x, input bit en, input bit sw,
                         output int got, output int held, output int exp);
      exp = en ? int'(mdl[mFront][x]) : 0;
      if (en) mdl[mFront][x] = '0;
      if (sw) mFront = ~mFront;
      clk6m = 1'b1; rdEn = en; rdX = x; swp = sw;
      @(posedge clk); #1;
      got = int'(objD);
      @(negedge clk);
      swp = 1'b0; rdEn = 1'b0;
      @(negedge clk);
      clk6m = 1'b0;
      @(negedge clk);
      @(posedge clk); #1;
      held = int'(objD);
      @(negedge clk);
   endtask

   task automatic applyStimulus(input vec_t v, input int idx);
      int got, held, exp;
      case (v.op)
         OP_WR:   doWrite(v.x, v.d, 1'b0);
         OP_SWAP: doSwap();
         default: begin
            doRead(v.x, v.en, 1'b0, got, held, exp);
            checkOutput($sformatf("tbl%0d_now", idx), got, int'(v.exp));
            checkOutput($sformatf("tbl%0d_hold", idx), held, int'(v.exp));
         end
      endcase
   endtask

   initial begin
      int got, held, exp;

      tbl[0]  = '{OP_WR,   8'h10, 6'h2D, 1'b0, 6'h00};
      tbl[1]  = '{OP_WR,   8'h20, 6'h05, 1'b0, 6'h00};
      tbl[2]  = '{OP_WR,   8'h20, 6'h3A, 1'b0, 6'h00};
      tbl[3]  = '{OP_WR,   8'h20, 6'h0C, 1'b0, 6'h00};
      tbl[4]  = '{OP_WR,   8'h40, 6'h22, 1'b0, 6'h00};
      tbl[5]  = '{OP_SWAP, 8'h00, 6'h00, 1'b0, 6'h00};
      tbl[6]  = '{OP_RD,   8'h10, 6'h00, 1'b1, 6'h2D};
      tbl[7]  = '{OP_RD,   8'h20, 6'h00, 1'b1, 6'h05};
      tbl[8]  = '{OP_RD,   8'h40, 6'h00, 1'b0, 6'h00};
      tbl[9]  = '{OP_RD,   8'h40, 6'h00, 1'b1, 6'h22};
      tbl[10] = '{OP_SWAP, 8'h00, 6'h00, 1'b0, 6'h00};
      tbl[11] = '{OP_SWAP, 8'h00, 6'h00, 1'b0, 6'h00};
      tbl[12] = '{OP_RD,   8'h10, 6'h00, 1'b1, 6'h00};

      resetN = 1'b0; clk6m = 1'b0; swp = 1'b0; wrEn = 1'b0;
      wrX = '0; wrD = '0; rdEn = 1'b0; rdX = '0;
      modelReset();
      repeat (3) @(posedge clk);
      #1;
      checkOutput("rstObj", int'(objD), 0);
      checkOutput("rstRdy", int'(wrRdy), 0);
      checkOutput("rstDone", int'(initDone), 0);
      @(negedge clk);
      waitInit();

      // Swap strobe during CHECK: data still lands in the bank latched at accept.
      doWrite(8'h30, 6'h11, 1'b1);
      doRead(8'h30, 1'b1, 1'b0, got, held, exp);
      checkOutput("swapCheck_now", got, 'h11);
      checkOutput("swapCheck_hold", held, 'h11);

      for (int i = 0; i < 13; i++) applyStimulus(tbl[i], i);

      // Swap coinciding with ce_6m: the read still uses the pre-swap front bank.
      doWrite(8'h50, 6'h1F, 1'b0);
      doRead(8'h50, 1'b1, 1'b1, got, held, exp);
      checkOutput("swapCe_old", got, 0);
      doRead(8'h50, 1'b1, 1'b0, got, held, exp);
      checkOutput("swapCe_new", got, 'h1F);

      for (int i = 0; i < 150; i++) begin
         int sel;
         sel = int'($urandom_range(0, 9));
         if (sel < 5) begin
            doWrite(8'(8'h80 + $urandom_range(0, 7)), 6'($urandom), 1'b0);
         end else if (sel < 8) begin
            doRead(8'(8'h80 + $urandom_range(0, 7)), ($urandom_range(0, 3) != 0), 1'b0,
                   got, held, exp);
            checkOutput($sformatf("rnd%0d_now", i), got, exp);
            checkOutput($sformatf("rnd%0d_hold", i), held, exp);
         end else begin
            doSwap();
         end
      end

      // Reset asserted during COMMIT abandons the write and restarts the sweep.
      waitRdy();
      wrEn = 1'b1; wrX = 8'h60; wrD = 6'h15;
      @(negedge clk);
      wrEn = 1'b0;
      @(negedge clk);
      resetN = 1'b0;
      @(posedge clk); #1;
      checkOutput("midRstRdy", int'(wrRdy), 0);
      checkOutput("midRstDone", int'(initDone), 0);
      @(negedge clk);
      waitInit();
      for (int b = 0; b < 2; b++) begin
         doRead(8'h60, 1'b1, 1'b0, got, held, exp);
         checkOutput($sformatf("postRst%0d_60", b), got, 0);
         doRead(8'h80, 1'b1, 1'b0, got, held, exp);
         checkOutput($sformatf("postRst%0d_80", b), got, 0);
         doSwap();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
